// File: rtl/decode_stage_pkg.sv
// Shared core types: fetch bundle, decoded-operation record, operation classes
// and RV32I base opcodes.
package core;

    localparam int unsigned ADDR_WIDTH = 30;
    localparam int unsigned INSN_WIDTH = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [INSN_WIDTH-1:0] insn;
    } InsnBundle;

    typedef enum logic [3:0] {
        ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL
    } OpClass;

    typedef struct packed {
        OpClass      cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        illegal;
    } DecodedOps;

endpackage

// File: rtl/decode_stage_if.sv
// Fetch-to-decode handshake: instruction bundle forward, ready backward.
interface decode_stage_if;
    import core::*;

    InsnBundle insn;
    logic      in_ready;

    modport master (output insn, input  in_ready);
    modport slave  (input  insn, output in_ready);
endinterface

// File: rtl/decode_stage_decoder.sv
// Combinational RV32I decoder: class, register fields, sign-extended
// immediate and register-usage flags.
module insn_decoder
    import core::*;
#(
    parameter int unsigned INSN_WIDTH = core::INSN_WIDTH
) (
    input  logic [INSN_WIDTH-1:0] insn_i,
    output DecodedOps             dec_o,
    output logic                  uses_rs1_o,
    output logic                  uses_rs2_o,
    output logic                  writes_rd_o
);

    OpClass      cls;
    logic [31:0] imm;

    always_comb begin
        cls = ILLEGAL;
        case (insn_i[6:0])
            OPC_OP:     cls = ALU_R;
            OPC_OP_IMM: cls = ALU_I;
            OPC_LOAD:   cls = LOAD;
            OPC_STORE:  cls = STORE;
            OPC_BRANCH: cls = BRANCH;
            OPC_JAL:    cls = JAL;
            OPC_JALR:   cls = JALR;
            OPC_LUI:    cls = LUI;
            OPC_AUIPC:  cls = AUIPC;
            OPC_SYSTEM: cls = SYSTEM;
            default:    cls = ILLEGAL;
        endcase
    end

    always_comb begin
        imm         = '0;
        uses_rs1_o  = 1'b0;
        uses_rs2_o  = 1'b0;
        writes_rd_o = 1'b0;
        case (cls)
            ALU_R: begin
                uses_rs1_o  = 1'b1;
                uses_rs2_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            ALU_I, LOAD, JALR: begin
                imm         = {{20{insn_i[31]}}, insn_i[31:20]};
                uses_rs1_o  = 1'b1;
                writes_rd_o = 1'b1;
            end
            STORE: begin
                imm        = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            BRANCH: begin
                imm        = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                              insn_i[30:25], insn_i[11:8], 1'b0};
                uses_rs1_o = 1'b1;
                uses_rs2_o = 1'b1;
            end
            JAL: begin
                imm         = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                               insn_i[20], insn_i[30:21], 1'b0};
                writes_rd_o = 1'b1;
            end
            LUI, AUIPC: begin
                imm         = {insn_i[31:12], 12'b0};
                writes_rd_o = 1'b1;
            end
            // CSR-style I-immediate; no scoreboard involvement
            SYSTEM:  imm = {{20{insn_i[31]}}, insn_i[31:20]};
            default: imm = '0;
        endcase
    end

    always_comb begin
        dec_o         = '0;
        dec_o.cls     = cls;
        dec_o.rd      = insn_i[11:7];
        dec_o.rs1     = insn_i[19:15];
        dec_o.rs2     = insn_i[24:20];
        dec_o.imm     = imm;
        dec_o.illegal = (cls == ILLEGAL);
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: one-entry hold register, RAW scoreboard against writeback,
// hazard back-pressure to fetch and a saturating stall counter.
module decode_stage #(
    parameter int unsigned ADDR_WIDTH      = core::ADDR_WIDTH,
    parameter int unsigned INSN_WIDTH      = core::INSN_WIDTH,
    parameter int unsigned NUM_REGS        = 32,
    parameter int unsigned STALL_CNT_WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    decode_stage_if.slave              fe,
    input  logic                       flush,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    output core::InsnBundle            stage_out_insn,
    output core::DecodedOps            out_dec,
    output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);
    import core::*;

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    if (ADDR_WIDTH != core::ADDR_WIDTH || INSN_WIDTH != core::INSN_WIDTH || IDX_W != 5) begin : g_param_check
        $error("decode_stage: widths must match the core package bundle and 5-bit register indices");
    end

    InsnBundle           hold_q;
    logic [NUM_REGS-1:0] sb_q, sb_d;
    DecodedOps           hold_dec;
    logic                uses_rs1, uses_rs2, writes_rd;
    logic                hazard, issue, accept, stall;

    insn_decoder #(.INSN_WIDTH(INSN_WIDTH)) u_dec (
        .insn_i      (hold_q.insn),
        .dec_o       (hold_dec),
        .uses_rs1_o  (uses_rs1),
        .uses_rs2_o  (uses_rs2),
        .writes_rd_o (writes_rd)
    );

    // Registered scoreboard only: a same-cycle writeback releases next cycle.
    assign hazard = (uses_rs1 && hold_dec.rs1 != '0 && sb_q[hold_dec.rs1]) ||
                    (uses_rs2 && hold_dec.rs2 != '0 && sb_q[hold_dec.rs2]);
    assign issue       = hold_q.valid && !hazard && !flush;
    assign stall       = hold_q.valid && hazard && !flush;
    assign fe.in_ready = !hold_q.valid || issue;
    assign accept      = fe.insn.valid && fe.in_ready && !flush;

    always_comb begin
        sb_d = sb_q;
        if (wb_valid && wb_rd != '0)
            sb_d[wb_rd] = 1'b0;
        if (issue && writes_rd && hold_dec.rd != '0)
            sb_d[hold_dec.rd] = 1'b1;
        sb_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_q         <= '0;
            sb_q           <= '0;
            stage_out_insn <= '0;
            out_dec        <= '0;
            stall_cycles   <= '0;
        end else begin
            sb_q <= sb_d;

            if (flush)
                hold_q.valid <= 1'b0;
            else if (accept)
                hold_q <= fe.insn;
            else if (issue)
                hold_q.valid <= 1'b0;

            stage_out_insn.valid <= issue;
            if (issue) begin
                stage_out_insn.addr <= hold_q.addr;
                stage_out_insn.insn <= hold_q.insn;
                out_dec             <= hold_dec;
            end

            if (stall && stall_cycles != '1)
                stall_cycles <= stall_cycles + STALL_CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Randomized and directed checks of decode_stage against a behavioural
// model of the hold entry, scoreboard and stall counter.
module tb_decode_stage;
    import core::*;

    localparam logic [31:0] W_ADDI1 = 32'h00500093;
    localparam logic [31:0] W_ADDI2 = 32'h00700113;
    localparam logic [31:0] W_ADD3  = 32'h001081B3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, flush, wb_valid;
    logic [4:0] wb_rd;
    InsnBundle  out_insn;
    DecodedOps  out_dec;
    logic [15:0] stall_cycles;

    decode_stage_if fe();

    decode_stage #(.NUM_REGS(32), .STALL_CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .fe             (fe),
        .flush          (flush),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .stage_out_insn (out_insn),
        .out_dec        (out_dec),
        .stall_cycles   (stall_cycles)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    bit          m_hv;
    logic [29:0] m_ha;
    logic [31:0] m_hw;
    bit          m_sb [32];
    int unsigned m_cnt;
    bit          m_ov;
    logic [29:0] m_oa;
    logic [31:0] m_ow;

    function automatic OpClass ref_cls(input logic [31:0] w);
        case (w[6:0])
            7'h33: return ALU_R;
            7'h13: return ALU_I;
            7'h03: return LOAD;
            7'h23: return STORE;
            7'h63: return BRANCH;
            7'h6F: return JAL;
            7'h67: return JALR;
            7'h37: return LUI;
            7'h17: return AUIPC;
            7'h73: return SYSTEM;
            default: return ILLEGAL;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] w);
        int v;
        case (ref_cls(w))
            ALU_I, LOAD, JALR, SYSTEM: v = $signed(w[31:20]);
            STORE:       v = $signed({w[31:25], w[11:7]});
            BRANCH:      v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            JAL:         v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            LUI, AUIPC:  v = int'(w[31:12]) * 4096;
            default:     v = 0;
        endcase
        return 32'(v);
    endfunction

    function automatic bit reads1(input OpClass c);
        return c inside {ALU_R, ALU_I, LOAD, STORE, BRANCH, JALR};
    endfunction
    function automatic bit reads2(input OpClass c);
        return c inside {ALU_R, STORE, BRANCH};
    endfunction
    function automatic bit writes(input OpClass c);
        return c inside {ALU_R, ALU_I, LOAD, JAL, JALR, LUI, AUIPC};
    endfunction

    function automatic logic [31:0] gen_word();
        logic [31:0] w;
        logic [6:0]  ops [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                  7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        int unsigned k;
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 10) w[6:0] = ops[k];
        else        w[1:0] = 2'($urandom_range(0, 2));
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        return w;
    endfunction

    // One clock: drive at negedge, check in_ready, advance model at posedge, check outputs.
    task automatic step(input bit r, input bit v, input logic [31:0] w,
                        input bit fl, input bit wv, input logic [4:0] wr);
        logic [29:0] a;
        OpClass      c;
        bit          haz, iss, rdy;
        @(negedge clk);
        a = 30'($urandom);
        rst = r;
        fe.insn.valid = v;
        fe.insn.addr  = a;
        fe.insn.insn  = w;
        flush = fl;
        wb_valid = wv;
        wb_rd = wr;
        c   = ref_cls(m_hw);
        haz = m_hv && ((reads1(c) && m_hw[19:15] != 0 && m_sb[m_hw[19:15]]) ||
                       (reads2(c) && m_hw[24:20] != 0 && m_sb[m_hw[24:20]]));
        iss = m_hv && !haz && !fl;
        rdy = !m_hv || iss;
        #1;
        check("in_ready", 64'(fe.in_ready), 64'(rdy));
        @(posedge clk);
        if (!r) begin
            m_hv = 0; m_ov = 0; m_cnt = 0;
            foreach (m_sb[i]) m_sb[i] = 0;
        end else begin
            m_ov = iss;
            if (iss) begin m_oa = m_ha; m_ow = m_hw; end
            if (haz && m_hv && !fl && m_cnt < 65535) m_cnt++;
            if (wv && wr != 0) m_sb[wr] = 0;
            if (iss && writes(c) && m_hw[11:7] != 0) m_sb[m_hw[11:7]] = 1;
            if (fl) m_hv = 0;
            else if (v && rdy) begin m_hv = 1; m_ha = a; m_hw = w; end
            else if (iss) m_hv = 0;
        end
        #1;
        check("out_valid", 64'(out_insn.valid), 64'(m_ov));
        check("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
        if (!r) check("rst_dec", 64'(out_dec), 64'd0);
        if (m_ov) begin
            check("out_addr", 64'(out_insn.addr), 64'(m_oa));
            check("out_insn", 64'(out_insn.insn), 64'(m_ow));
            check("cls", 64'(out_dec.cls), 64'(ref_cls(m_ow)));
            check("rd", 64'(out_dec.rd), 64'(m_ow[11:7]));
            check("rs1", 64'(out_dec.rs1), 64'(m_ow[19:15]));
            check("rs2", 64'(out_dec.rs2), 64'(m_ow[24:20]));
            check("imm", 64'(out_dec.imm), 64'(ref_imm(m_ow)));
            check("illegal", 64'(out_dec.illegal), 64'(ref_cls(m_ow) == ILLEGAL));
        end
    endtask

    task automatic idle();
        step(1, 0, '0, 0, 0, '0);
    endtask

    task automatic feed(input logic [31:0] w);
        step(1, 1, w, 0, 0, '0);
    endtask

    initial begin
        rst = 0; flush = 0; wb_valid = 0; wb_rd = '0;
        fe.insn = '0;
        m_hv = 0; m_ov = 0; m_cnt = 0; m_ha = '0; m_hw = '0; m_oa = '0; m_ow = '0;
        foreach (m_sb[i]) m_sb[i] = 0;

        step(0, 0, '0, 0, 0, '0);
        step(0, 0, '0, 0, 0, '0);
        check("reset_ready", 64'(fe.in_ready), 64'd1);

        // RAW on x1, released by writeback
        feed(W_ADDI1);
        feed(W_ADD3);
        check("raw_ready", 64'(fe.in_ready), 64'd0);
        idle(); idle(); idle();
        step(1, 0, '0, 0, 1, 5'd1);
        idle();
        check("raw_issue", 64'(out_insn.valid), 64'd1);
        check("raw_word", 64'(out_insn.insn), 64'(W_ADD3));
        check("raw_stalls", 64'(stall_cycles), 64'd4);

        // Independent pair: back-to-back outputs
        feed(W_ADDI1);
        feed(W_ADDI2);
        check("pair_imm0", 64'(out_dec.imm), 64'd5);
        check("pair_rd0", 64'(out_dec.rd), 64'd1);
        idle();
        check("pair_v1", 64'(out_insn.valid), 64'd1);
        check("pair_imm1", 64'(out_dec.imm), 64'd7);
        check("pair_rd1", 64'(out_dec.rd), 64'd2);

        // x0 destinations and sources never stall
        feed(32'h00500013);
        feed(32'h00000093);
        idle();
        check("x0_stalls", 64'(stall_cycles), 64'd4);

        // addi x1 issues in the cycle x1 writes back: set wins
        feed(W_ADDI1);
        step(1, 0, '0, 0, 1, 5'd1);
        feed(W_ADD3);
        check("simul_ready", 64'(fe.in_ready), 64'd0);

        // Flush during the stall
        step(1, 0, '0, 1, 0, '0);
        check("flush_valid", 64'(out_insn.valid), 64'd0);
        check("flush_ready", 64'(fe.in_ready), 64'd1);
        feed(W_ADD3);
        check("flush_sb_kept", 64'(fe.in_ready), 64'd0);

        // Reset mid-stall
        step(0, 0, '0, 0, 0, '0);
        check("mrst_valid", 64'(out_insn.valid), 64'd0);
        check("mrst_stalls", 64'(stall_cycles), 64'd0);
        check("mrst_ready", 64'(fe.in_ready), 64'd1);
        feed(W_ADD3);
        idle();
        check("mrst_sb_clear", 64'(out_insn.valid), 64'd1);

        // Illegal word
        feed(32'hFFFFFFFF);
        idle();
        check("ill_flag", 64'(out_dec.illegal), 64'd1);
        check("ill_cls", 64'(out_dec.cls), 64'(ILLEGAL));

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7, gen_word(),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
                 5'($urandom_range(0, 3)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
